app_dot_accum40: RTL and testbench

APP_DOT_ACCUM40 -- requirements
Module: app_dot_accum40

---
 rtl/app_dot_accum40_pkg.sv | 14 +
 rtl/app_sat40to32.sv | 25 ++
 rtl/app_dot_accum40.sv | 107 ++++++++++
 tb/tb_app_dot_accum40.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/app_dot_accum40_pkg.sv
// Shared definitions for the multiplier-family blocks: FSM state encoding
// and the signed 32-bit saturation bounds.
package app_dot_accum40_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/app_sat40to32.sv
// Combinational clamp of a wide signed accumulator into the signed 32-bit range.
module app_sat40to32
  import app_dot_accum40_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [31:0]      sat_o,
  output logic             sat_flag_o
);

  logic sign;
  logic over_pos;
  logic over_neg;

  // The value fits in 32 bits only when every bit above bit 31 equals the sign bit.
  assign sign     = acc_i[ACC_W-1];
  assign over_pos = !sign && (|acc_i[ACC_W-2:31]);
  assign over_neg = sign && !(&acc_i[ACC_W-2:31]);

  assign sat_flag_o = over_pos || over_neg;
  assign sat_o      = over_pos ? SAT_MAX :
                      over_neg ? SAT_MIN : acc_i[31:0];

endmodule

// File: rtl/app_dot_accum40.sv
// Dot-product accumulator: sums a run of signed 32-bit products into a wide
// accumulator and presents the full-precision and 32-bit saturated results.
module app_dot_accum40
  import app_dot_accum40_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      prod,
  input  logic             prod_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic [31:0]      sat_out,
  output logic             sat_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             drop
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      sat_q, sat_d;
  logic             flag_q, flag_d;
  logic             drop_q, drop_d;
  logic [ACC_W-1:0] prod_ext;

  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    drop_d  = prod_valid && (state_q != ST_ACCUM);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
          if (len == '0) begin
            state_d = ST_HOLD;
          end else begin
            cnt_d   = len;
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (prod_valid) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Dropping enable aborts any run and returns everything to reset values.
    if (!en) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      drop_d  = 1'b0;
    end
  end

  // Saturate the next accumulator value so sat_out registers alongside acc_out.
  app_sat40to32 #(.ACC_W(ACC_W)) u_sat (
    .acc_i      (acc_d),
    .sat_o      (sat_d),
    .sat_flag_o (flag_d)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= '0;
      flag_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      flag_q  <= flag_d;
      drop_q  <= drop_d;
    end
  end

  assign acc_out   = acc_q;
  assign sat_out   = sat_q;
  assign sat_flag  = flag_q;
  assign drop      = drop_q;
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_app_dot_accum40.sv
// Directed self-checking bench for app_dot_accum40 with hand-computed expectations.
module tb_app_dot_accum40;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        en;
  logic        start;
  logic [7:0]  len;
  logic [31:0] prod;
  logic        prod_valid;
  logic [39:0] acc_out;
  logic [31:0] sat_out;
  logic        sat_flag;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        drop;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  app_dot_accum40 #(.ACC_W(40), .LEN_W(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .en         (en),
    .start      (start),
    .len        (len),
    .prod       (prod),
    .prod_valid (prod_valid),
    .acc_out    (acc_out),
    .sat_out    (sat_out),
    .sat_flag   (sat_flag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .drop       (drop)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    en         = 1'b1;
    start      = 1'b0;
    len        = 8'd0;
    prod       = 32'd0;
    prod_valid = 1'b0;
    out_ready  = 1'b0;
    #3;
    check("rst_acc", acc_out, 0);
    check("rst_sat", sat_out, 0);
    check("rst_flag", sat_flag, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    #10 sys_rst_n = 1'b1;
    step();

    // len=3: 100 - 50 + 7 = 57
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0; check("r1_busy", busy, 1);
    prod_valid = 1'b1; prod = 32'd100;
    step();
    prod = -32'sd50;
    step();
    check("r1_not_yet", out_valid, 0);
    prod = 32'd7;
    step();
    prod_valid = 1'b0;
    check("r1_valid", out_valid, 1);
    check("r1_acc", acc_out, 57);
    check("r1_sat", sat_out, 57);
    check("r1_flag", sat_flag, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("r1_done_valid", out_valid, 0);
    check("r1_done_busy", busy, 0);

    // prod_valid while idle is discarded and pulses drop
    prod_valid = 1'b1; prod = 32'd1234;
    step();
    prod_valid = 1'b0;
    check("idle_drop", drop, 1);
    check("idle_acc_kept", acc_out, 57);
    step();
    check("idle_drop_pulse", drop, 0);

    // len=4, four products of 2^30 -> 2^32, positive saturation
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0; prod_valid = 1'b1; prod = 32'h4000_0000;
    repeat (4) step();
    prod_valid = 1'b0;
    check("r2_valid", out_valid, 1);
    check("r2_acc", acc_out, 40'h01_0000_0000);
    check("r2_sat", sat_out, 32'h7FFF_FFFF);
    check("r2_flag", sat_flag, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // len=2, two products of -2^31 -> -2^32, negative saturation
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0; prod_valid = 1'b1; prod = 32'h8000_0000;
    repeat (2) step();
    prod_valid = 1'b0;
    check("r3_acc", acc_out, 40'hFF_0000_0000);
    check("r3_sat", sat_out, 32'h8000_0000);
    check("r3_flag", sat_flag, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // len=2 with gaps: valid pattern 1,0,0,1 carrying 5 and 9
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0; prod_valid = 1'b1; prod = 32'd5;
    step();
    prod_valid = 1'b0; prod = 32'd777;
    check("r4_drop0", drop, 0);
    step();
    check("r4_gap_valid", out_valid, 0);
    step();
    prod_valid = 1'b1; prod = 32'd9;
    step();
    prod_valid = 1'b0;
    check("r4_valid", out_valid, 1);
    check("r4_acc", acc_out, 14);
    check("r4_drop1", drop, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // len=0 goes straight to HOLD; held outputs stable and start ignored
    start = 1'b1; len = 8'd0;
    step();
    check("r5_valid", out_valid, 1);
    check("r5_acc", acc_out, 0);
    for (int i = 0; i < 5; i++) begin
      start = i[0]; len = 8'd5; prod_valid = 1'b0;
      step();
      check("r5_hold_valid", out_valid, 1);
      check("r5_hold_acc", acc_out, 0);
      check("r5_hold_sat", sat_out, 0);
    end
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    check("r5_ready_start_ignored", busy, 0);
    step();
    check("r5_idle", busy, 0);

    // asynchronous reset mid-run clears outputs before the next edge
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0; prod_valid = 1'b1; prod = 32'd1000;
    repeat (2) step();
    check("r6_partial", acc_out, 2000);
    #2 sys_rst_n = 1'b0;
    #1;
    check("r6_rst_acc", acc_out, 0);
    check("r6_rst_sat", sat_out, 0);
    check("r6_rst_busy", busy, 0);
    check("r6_rst_valid", out_valid, 0);
    prod_valid = 1'b0;
    #1 sys_rst_n = 1'b1;
    step();

    // en low after 2 of 3 products aborts; fresh len=1 run of -1
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0; prod_valid = 1'b1; prod = 32'd10;
    repeat (2) step();
    prod_valid = 1'b0; en = 1'b0;
    step();
    en = 1'b1;
    check("r7_abort_busy", busy, 0);
    check("r7_abort_acc", acc_out, 0);
    step();
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0; prod_valid = 1'b1; prod = 32'hFFFF_FFFF;
    step();
    prod_valid = 1'b0;
    check("r7_valid", out_valid, 1);
    check("r7_acc", acc_out, 40'hFF_FFFF_FFFF);
    check("r7_sat", sat_out, 32'hFFFF_FFFF);
    check("r7_flag", sat_flag, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
